// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice.
//   RES_W         : ALU result width
//   OP_*          : 4-bit ALU opcodes (bit 3 set selects a 4-bit logic op)
//   state_t       : arbiter FSM states
package alu_pkg;

  localparam int RES_W = 6;

  localparam logic [3:0] OP_INC_A  = 4'h0;  // a + 1
  localparam logic [3:0] OP_DEC_A  = 4'h1;  // a - 1
  localparam logic [3:0] OP_DBL_A  = 4'h2;  // a * 2
  localparam logic [3:0] OP_INC_B  = 4'h3;  // b + 1
  localparam logic [3:0] OP_DEC_B  = 4'h4;  // b - 1
  localparam logic [3:0] OP_DBL_B  = 4'h5;  // b + b
  localparam logic [3:0] OP_ADD    = 4'h6;  // a + b
  localparam logic [3:0] OP_QUAD_A = 4'h7;  // a * 4
  localparam logic [3:0] OP_NOT_A  = 4'h8;
  localparam logic [3:0] OP_NOT_B  = 4'h9;
  localparam logic [3:0] OP_AND    = 4'hA;
  localparam logic [3:0] OP_OR     = 4'hB;
  localparam logic [3:0] OP_XOR    = 4'hC;
  localparam logic [3:0] OP_XNOR   = 4'hD;
  localparam logic [3:0] OP_NAND   = 4'hE;
  localparam logic [3:0] OP_NOR    = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit unsigned ALU, 16 ops, 6-bit result.
// Arithmetic ops wrap mod 64 on zero-extended operands; logic ops yield a
// 4-bit value zero-extended to 6 bits.
// Ports:
//   a, b : 4-bit operands
//   s    : 4-bit opcode
//   y    : 6-bit result
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [3:0]       s,
  output logic [RES_W-1:0] y
);

  logic [RES_W-1:0] w_a6;
  logic [RES_W-1:0] w_b6;

  assign w_a6 = {2'b00, a};
  assign w_b6 = {2'b00, b};

  always_comb begin
    y = '0;
    case (s)
      OP_INC_A:  y = w_a6 + 6'd1;
      OP_DEC_A:  y = w_a6 - 6'd1;
      OP_DBL_A:  y = {1'b0, a, 1'b0};
      OP_INC_B:  y = w_b6 + 6'd1;
      OP_DEC_B:  y = w_b6 - 6'd1;
      OP_DBL_B:  y = {1'b0, b, 1'b0};
      OP_ADD:    y = w_a6 + w_b6;
      OP_QUAD_A: y = {a, 2'b00};
      OP_NOT_A:  y = {2'b00, ~a};
      OP_NOT_B:  y = {2'b00, ~b};
      OP_AND:    y = {2'b00, a & b};
      OP_OR:     y = {2'b00, a | b};
      OP_XOR:    y = {2'b00, a ^ b};
      OP_XNOR:   y = {2'b00, ~(a ^ b)};
      OP_NAND:   y = {2'b00, ~(a & b)};
      OP_NOR:    y = {2'b00, ~(a | b)};
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one alu_core among NUM_REQ requesters.
// One command is in flight at a time: IDLE (grant+latch) -> EXEC (compute,
// register result) -> RESP (hold result until the consumer accepts).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester command handshake (ready one-hot)
//   req_op/req_a/req_b    : per-requester 4-bit slices, slice i at [4*i+:4]
//   rsp_valid/rsp_ready   : result handshake, result held under backpressure
//   rsp_id, rsp_y         : issuing requester index and ALU result
//   busy                  : high whenever a command is in flight
//   ops_done              : wrapping count of accepted responses
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_op,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [RES_W-1:0]     rsp_y,
  output logic                 busy,
  output logic [CNT_W-1:0]     ops_done
);

  state_t           r_state;
  state_t           w_next;

  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_grant;
  logic [3:0]       r_op;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [RES_W-1:0] r_rsp_y;
  logic [CNT_W-1:0] r_ops_done;

  logic             w_any;
  logic [ID_W-1:0]  w_grant;
  logic [ID_W-1:0]  w_scan;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [3:0]       w_op_sel;
  logic [3:0]       w_a_sel;
  logic [3:0]       w_b_sel;
  logic [RES_W-1:0] w_alu_y;

  // Scan requesters starting at r_rr_ptr and wrapping; first valid one wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_scan  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_scan = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_any && req_valid[w_scan]) begin
        w_any   = 1'b1;
        w_grant = w_scan;
      end
    end
  end

  // Explicit wrap so non-power-of-two NUM_REQ stays in range.
  assign w_ptr_nxt = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);

  // Select the granted requester's command slices.
  always_comb begin
    w_op_sel = '0;
    w_a_sel  = '0;
    w_b_sel  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant == ID_W'(k)) begin
        w_op_sel = req_op[4*k +: 4];
        w_a_sel  = req_a[4*k +: 4];
        w_b_sel  = req_b[4*k +: 4];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs: ready only toward the granted requester while idle.
  always_comb begin
    req_ready = '0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_any) req_ready[w_grant] = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, result register, completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= '0;
      r_ops_done  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op     <= w_op_sel;
            r_a      <= w_a_sel;
            r_b      <= w_b_sel;
            r_grant  <= w_grant;
            r_rr_ptr <= w_ptr_nxt;
          end
        end
        EXEC: begin
          r_rsp_y     <= w_alu_y;
          r_rsp_id    <= r_grant;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ops_done  <= r_ops_done + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  alu_core u_alu (
    .a (r_a),
    .b (r_b),
    .s (r_op),
    .y (w_alu_y)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int CNT_W   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_op;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [5:0]           rsp_y;
  logic                 busy;
  logic [CNT_W-1:0]     ops_done;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_ptr = 0;   // next requester favoured by round-robin
  int exp_ops = 0;   // accepted responses since reset

  typedef struct {
    int id;
    int op;
    int a;
    int b;
    int exp_y;
  } vec_t;

  vec_t vecs[12];

  // Reference ALU straight from the opcode table, plain integer arithmetic.
  function automatic int ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0:  r = a + 1;
      1:  r = a - 1 + 64;
      2:  r = a * 2;
      3:  r = b + 1;
      4:  r = b - 1 + 64;
      5:  r = b + b;
      6:  r = a + b;
      7:  r = a * 4;
      8:  r = 15 - a;
      9:  r = 15 - b;
      10: r = a & b;
      11: r = a | b;
      12: r = a ^ b;
      13: r = 15 - (a ^ b);
      14: r = 15 - (a & b);
      default: r = 15 - (a | b);
    endcase
    return r % 64;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
  endtask

  task automatic set_req(input int id, input bit v, input int op, input int a, input int b);
    req_valid[id]     = v;
    req_op[4*id +: 4] = op[3:0];
    req_a[4*id +: 4]  = a[3:0];
    req_b[4*id +: 4]  = b[3:0];
  endtask

  // Called just after a falling edge; returns #1 after the handshake edge.
  task automatic issue(input int id, input int op, input int a, input int b, output bit ok);
    ok = 1'b0;
    set_req(id, 1'b1, op, a, b);
    for (int t = 0; t < 20; t++) begin
      #1;
      if (req_ready[id] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      timeout_fail("grant_wait");
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    exp_ptr = (id + 1) % NUM_REQ;
  endtask

  // Counts falling edges until rsp_valid is seen.
  task automatic wait_rsp(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (rsp_valid !== 1'b1 && cnt < 20);
    if (rsp_valid !== 1'b1) timeout_fail("rsp_wait");
  endtask

  task automatic txn(input int id, input int op, input int a, input int b, input int exp_y);
    bit ok;
    int cnt;
    issue(id, op, a, b, ok);
    if (!ok) return;
    wait_rsp(cnt);
    check("latency", cnt, 2);
    check("rsp_y", 32'(rsp_y), exp_y);
    check("rsp_id", 32'(rsp_id), id);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_ops++;
    check("rsp_valid_clr", 32'(rsp_valid), 0);
    check("ops_done", 32'(ops_done), exp_ops % 65536);
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    int cnt;
    int eid;
    int g;
    bit m_out;
    int m_hs, m_id, m_y;
    bit exp_rv;
    logic [NUM_REQ-1:0] exp_rdy;
    int opv, av, bv;

    vecs[0]  = '{0, 6,  9,  8, 17};
    vecs[1]  = '{0, 1,  0,  0, 63};
    vecs[2]  = '{1, 7, 15,  0, 60};
    vecs[3]  = '{0, 8, 10,  0,  5};
    vecs[4]  = '{1, 15, 0,  0, 15};
    vecs[5]  = '{0, 4,  3,  0, 63};
    vecs[6]  = '{1, 2, 15,  0, 30};
    vecs[7]  = '{0, 5,  0, 15, 30};
    vecs[8]  = '{1, 10, 12, 10, 8};
    vecs[9]  = '{0, 13, 12, 10, 9};
    vecs[10] = '{1, 14, 15, 15, 0};
    vecs[11] = '{0, 3,  0, 15, 16};

    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_y", 32'(rsp_y), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ops_done", 32'(ops_done), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // Directed vectors, one requester at a time
    foreach (vecs[i]) txn(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_y);

    // Fairness: both requesters held valid across six commands
    set_req(0, 1'b1, 6, 1, 2);
    set_req(1, 1'b1, 6, 3, 4);
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_rsp(cnt);
      eid = exp_ptr;
      check("fair_id", 32'(rsp_id), eid);
      check("fair_y", 32'(rsp_y), (eid == 0) ? ref_alu(6, 1, 2) : ref_alu(6, 3, 4));
      exp_ptr = (eid + 1) % NUM_REQ;
      @(posedge clk);
      exp_ops++;
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    check("fair_ops_done", 32'(ops_done), exp_ops);

    // Backpressure: result held for ten cycles while another requester waits
    @(negedge clk);
    issue(0, 6, 5, 7, ok);
    wait_rsp(cnt);
    req_valid[1] = 1'b1;
    for (int h = 0; h < 10; h++) begin
      #1;
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_y", 32'(rsp_y), 12);
      check("bp_rsp_id", 32'(rsp_id), 0);
      check("bp_req_ready", 32'(req_ready), 0);
      check("bp_ops_done", 32'(ops_done), exp_ops);
      check("bp_busy", 32'(busy), 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid[1] = 1'b0;   // dropped before ever being granted
    @(posedge clk);
    #1;
    exp_ops++;
    check("bp_accept_ops", 32'(ops_done), exp_ops);
    check("bp_accept_valid", 32'(rsp_valid), 0);
    rsp_ready = 1'b0;
    @(negedge clk);
    // Pointer still favours requester 1 after the withdrawn request
    set_req(0, 1'b1, 0, 0, 0);
    set_req(1, 1'b1, 0, 0, 0);
    #1;
    check("rr_no_adv", 32'(req_ready), 32'(1 << exp_ptr));
    req_valid = '0;
    @(negedge clk);

    // Reset while the operation is executing
    issue(1, 6, 9, 8, ok);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_y", 32'(rsp_y), 0);
    check("mid_rst_id", 32'(rsp_id), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ops", 32'(ops_done), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    exp_ptr = 0;
    exp_ops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1, 0, 5, 0, 6);

    // Randomised traffic against a transaction-level model
    m_out = 1'b0; m_hs = 0; m_id = 0; m_y = 0;
    for (int c = 0; c < 600; c++) begin
      req_valid = NUM_REQ'($urandom_range(0, 3));
      req_op    = 8'($urandom);
      req_a     = 8'($urandom);
      req_b     = 8'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rv = m_out && (c >= m_hs + 2);
      g = -1;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (g < 0 && req_valid[(exp_ptr + j) % NUM_REQ]) g = (exp_ptr + j) % NUM_REQ;
      end
      exp_rdy = (!m_out && g >= 0) ? NUM_REQ'(1 << g) : '0;
      check("rnd_busy", 32'(busy), 32'(m_out));
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rnd_ops_done", 32'(ops_done), exp_ops % 65536);
      if (exp_rv) begin
        check("rnd_rsp_id", 32'(rsp_id), m_id);
        check("rnd_rsp_y", 32'(rsp_y), m_y);
      end
      if (!m_out && g >= 0) begin
        opv = int'(req_op[4*g +: 4]);
        av  = int'(req_a[4*g +: 4]);
        bv  = int'(req_b[4*g +: 4]);
        m_out = 1'b1; m_hs = c; m_id = g; m_y = ref_alu(opv, av, bv);
        exp_ptr = (g + 1) % NUM_REQ;
      end else if (exp_rv && rsp_ready) begin
        m_out = 1'b0;
        exp_ops++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;

    // Exhaustive sweep through requester 1 from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 0;
    exp_ops = 0;
    @(negedge clk);
    for (int op = 0; op < 16; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          txn(1, op, a, b, ref_alu(op, a, b));
    check("exh_ops_done", 32'(ops_done), 4096 % 65536);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
